// File: rtl/icw_ocw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : icw_ocw_sequencer
// Purpose  : Command-word sequencer for an 8259-style interrupt controller.
//            Turns the decoder's write strobes into single write events,
//            steps through ICW1 -> ICW2 -> [ICW3] -> [ICW4], then routes
//            A1 writes to OCW1 (IMR) and A0 writes to OCW2/OCW3. Holds every
//            configuration register the resolver, cascade and mask logic use.
// Ports    : clk, reset_n (async, active low)
//            internal_bus[7:0]                  write data
//            write_ICW_1, write_ICW2_4,
//            write_OCW2, write_OCW3             level strobes (sync to clk)
//            init_done                          1 while in READY
//            level_trigger, single_mode         ICW1 LTIM / SNGL
//            vector_base[4:0]                   ICW2[7:3]
//            cascade_cfg[7:0]                   ICW3
//            auto_eoi, buffered_mode,
//            buffer_master, special_fully_nested ICW4 fields
//            interrupt_mask[7:0]                OCW1 / IMR
//            ocw2_valid, ocw2_cmd, ocw2_level   OCW2 pulse + fields
//            read_isr_sel, poll_cmd             OCW3 RR/RIS and P pulse
//            special_mask_mode                  SMM state
// Options  : SPECIAL_MASK_MODE_EN - enables OCW3 ESMM/SMM handling; when
//            undefined special_mask_mode is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module icw_ocw_sequencer #(
  parameter logic [7:0] IMR_RESET    = 8'h00,
  parameter logic [4:0] VECTOR_RESET = 5'b00000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] internal_bus,
  input  logic       write_ICW_1,
  input  logic       write_ICW2_4,
  input  logic       write_OCW2,
  input  logic       write_OCW3,
  output logic       init_done,
  output logic       level_trigger,
  output logic       single_mode,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic       auto_eoi,
  output logic       buffered_mode,
  output logic       buffer_master,
  output logic       special_fully_nested,
  output logic [7:0] interrupt_mask,
  output logic       ocw2_valid,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       read_isr_sel,
  output logic       poll_cmd,
  output logic       special_mask_mode
);

  localparam logic [2:0] ST_WAIT_ICW1 = 3'd0;
  localparam logic [2:0] ST_WAIT_ICW2 = 3'd1;
  localparam logic [2:0] ST_WAIT_ICW3 = 3'd2;
  localparam logic [2:0] ST_WAIT_ICW4 = 3'd3;
  localparam logic [2:0] ST_READY     = 3'd4;

  logic [2:0] state_q, state_d;
  logic [3:0] strobe_q;          // {OCW3, OCW2, A1, ICW1} from last cycle
  logic       ic4_q, ic4_d;
  logic       ltim_q, ltim_d;
  logic       sngl_q, sngl_d;
  logic [4:0] vec_q, vec_d;
  logic [7:0] cas_q, cas_d;
  logic       aeoi_q, aeoi_d;
  logic       buf_q, buf_d;
  logic       ms_q, ms_d;
  logic       sfnm_q, sfnm_d;
  logic [7:0] imr_q, imr_d;
  logic       valid_q, valid_d;
  logic [2:0] cmd_q, cmd_d;
  logic [2:0] lvl_q, lvl_d;
  logic       risr_q, risr_d;
  logic       poll_q, poll_d;

  logic [3:0] w_strobe;
  logic       ev_icw1, ev_a1, ev_ocw2, ev_ocw3;

  assign w_strobe = {write_OCW3, write_OCW2, write_ICW2_4, write_ICW_1};

  // Rising-edge detect: a strobe held high yields exactly one event.
  assign ev_icw1 = w_strobe[0] & ~strobe_q[0];
  assign ev_a1   = w_strobe[1] & ~strobe_q[1];
  assign ev_ocw2 = w_strobe[2] & ~strobe_q[2];
  assign ev_ocw3 = w_strobe[3] & ~strobe_q[3];

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_WAIT_ICW1;
      strobe_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      strobe_q <= w_strobe;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    if (ev_icw1) begin
      state_d = ST_WAIT_ICW2;
    end else if (ev_a1) begin
      case (state_q)
        ST_WAIT_ICW2: state_d = !sngl_q ? ST_WAIT_ICW3 :
                                (ic4_q  ? ST_WAIT_ICW4 : ST_READY);
        ST_WAIT_ICW3: state_d = ic4_q ? ST_WAIT_ICW4 : ST_READY;
        ST_WAIT_ICW4: state_d = ST_READY;
        ST_WAIT_ICW1,
        ST_READY:     state_d = state_q;
        default:      state_d = ST_WAIT_ICW1;
      endcase
    end
  end

  // ------------------------------------------------------------- output comb
  always_comb begin
    init_done = (state_q == ST_READY);
  end

`ifdef SPECIAL_MASK_MODE_EN
  logic smm_q, smm_d;
  assign special_mask_mode = smm_q;
`else
  assign special_mask_mode = 1'b0;
`endif

  // ------------------------------------------------------ register next values
  always_comb begin
    ic4_d   = ic4_q;
    ltim_d  = ltim_q;
    sngl_d  = sngl_q;
    vec_d   = vec_q;
    cas_d   = cas_q;
    aeoi_d  = aeoi_q;
    buf_d   = buf_q;
    ms_d    = ms_q;
    sfnm_d  = sfnm_q;
    imr_d   = imr_q;
    cmd_d   = cmd_q;
    lvl_d   = lvl_q;
    risr_d  = risr_q;
    valid_d = 1'b0;
    poll_d  = 1'b0;
`ifdef SPECIAL_MASK_MODE_EN
    smm_d   = smm_q;
`endif
    if (ev_icw1) begin
      ltim_d = internal_bus[3];
      sngl_d = internal_bus[1];
      ic4_d  = internal_bus[0];
      imr_d  = IMR_RESET;
      aeoi_d = 1'b0;
      buf_d  = 1'b0;
      ms_d   = 1'b0;
      sfnm_d = 1'b0;
      risr_d = 1'b0;
      cas_d  = 8'h00;
`ifdef SPECIAL_MASK_MODE_EN
      smm_d  = 1'b0;
`endif
    end else if (ev_a1) begin
      // A1 wins over a coincident OCW2/OCW3, which is then dropped.
      case (state_q)
        ST_WAIT_ICW2: vec_d = internal_bus[7:3];
        ST_WAIT_ICW3: cas_d = internal_bus;
        ST_WAIT_ICW4: begin
          sfnm_d = internal_bus[4];
          buf_d  = internal_bus[3];
          ms_d   = internal_bus[2];
          aeoi_d = internal_bus[1];
        end
        ST_READY:     imr_d = internal_bus;
        default:      imr_d = imr_q;
      endcase
    end else if (state_q == ST_READY) begin
      if (ev_ocw2) begin
        valid_d = 1'b1;
        cmd_d   = internal_bus[7:5];
        lvl_d   = internal_bus[2:0];
      end
      if (ev_ocw3) begin
        if (internal_bus[1]) risr_d = internal_bus[0];
        if (internal_bus[2]) poll_d = 1'b1;
`ifdef SPECIAL_MASK_MODE_EN
        if (internal_bus[6]) smm_d = internal_bus[5];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ic4_q   <= 1'b0;
      ltim_q  <= 1'b0;
      sngl_q  <= 1'b0;
      vec_q   <= VECTOR_RESET;
      cas_q   <= 8'h00;
      aeoi_q  <= 1'b0;
      buf_q   <= 1'b0;
      ms_q    <= 1'b0;
      sfnm_q  <= 1'b0;
      imr_q   <= IMR_RESET;
      valid_q <= 1'b0;
      cmd_q   <= 3'b000;
      lvl_q   <= 3'b000;
      risr_q  <= 1'b0;
      poll_q  <= 1'b0;
`ifdef SPECIAL_MASK_MODE_EN
      smm_q   <= 1'b0;
`endif
    end else begin
      ic4_q   <= ic4_d;
      ltim_q  <= ltim_d;
      sngl_q  <= sngl_d;
      vec_q   <= vec_d;
      cas_q   <= cas_d;
      aeoi_q  <= aeoi_d;
      buf_q   <= buf_d;
      ms_q    <= ms_d;
      sfnm_q  <= sfnm_d;
      imr_q   <= imr_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      lvl_q   <= lvl_d;
      risr_q  <= risr_d;
      poll_q  <= poll_d;
`ifdef SPECIAL_MASK_MODE_EN
      smm_q   <= smm_d;
`endif
    end
  end

  assign level_trigger        = ltim_q;
  assign single_mode          = sngl_q;
  assign vector_base          = vec_q;
  assign cascade_cfg          = cas_q;
  assign auto_eoi             = aeoi_q;
  assign buffered_mode        = buf_q;
  assign buffer_master        = ms_q;
  assign special_fully_nested = sfnm_q;
  assign interrupt_mask       = imr_q;
  assign ocw2_valid           = valid_q;
  assign ocw2_cmd             = cmd_q;
  assign ocw2_level           = lvl_q;
  assign read_isr_sel         = risr_q;
  assign poll_cmd             = poll_q;

endmodule
`default_nettype wire

// File: tb/tb_icw_ocw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_icw_ocw_sequencer
// Purpose  : Self-checking bench for icw_ocw_sequencer: directed sequences
//            followed by random strobe/data traffic, compared every cycle
//            against a queue-based model of the initialisation sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icw_ocw_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] internal_bus;
  logic       write_ICW_1, write_ICW2_4, write_OCW2, write_OCW3;
  logic       init_done, level_trigger, single_mode;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg;
  logic       auto_eoi, buffered_mode, buffer_master, special_fully_nested;
  logic [7:0] interrupt_mask;
  logic       ocw2_valid;
  logic [2:0] ocw2_cmd, ocw2_level;
  logic       read_isr_sel, poll_cmd, special_mask_mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  icw_ocw_sequencer dut (
    .clk(clk), .reset_n(reset_n), .internal_bus(internal_bus),
    .write_ICW_1(write_ICW_1), .write_ICW2_4(write_ICW2_4),
    .write_OCW2(write_OCW2), .write_OCW3(write_OCW3),
    .init_done(init_done), .level_trigger(level_trigger),
    .single_mode(single_mode), .vector_base(vector_base),
    .cascade_cfg(cascade_cfg), .auto_eoi(auto_eoi),
    .buffered_mode(buffered_mode), .buffer_master(buffer_master),
    .special_fully_nested(special_fully_nested),
    .interrupt_mask(interrupt_mask), .ocw2_valid(ocw2_valid),
    .ocw2_cmd(ocw2_cmd), .ocw2_level(ocw2_level),
    .read_isr_sel(read_isr_sel), .poll_cmd(poll_cmd),
    .special_mask_mode(special_mask_mode)
  );

  // ------------------------------------------------------------------ model
  // The init sequence is a queue of command words still owed after ICW1;
  // the device is ready once ICW1 has been seen and the queue is empty.
  typedef enum int {W_ICW2, W_ICW3, W_ICW4} icw_t;
  icw_t       pending[$];
  bit         started;
  bit  [3:0]  prev_strb;
  bit         m_ltim, m_sngl, m_ic4, m_aeoi, m_buf, m_ms, m_sfnm;
  bit         m_valid, m_risr, m_poll, m_smm;
  bit  [4:0]  m_vec;
  bit  [7:0]  m_cas, m_imr;
  bit  [2:0]  m_cmd, m_lvl;

  function automatic bit m_ready();
    return started && (pending.size() == 0);
  endfunction

  task automatic model_reset();
    pending.delete();
    started = 0; prev_strb = 0;
    m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_aeoi = 0; m_buf = 0; m_ms = 0;
    m_sfnm = 0; m_valid = 0; m_risr = 0; m_poll = 0; m_smm = 0;
    m_vec = 0; m_cas = 0; m_imr = 8'h00; m_cmd = 0; m_lvl = 0;
  endtask

  task automatic model_step(input bit [3:0] strb, input bit [7:0] d);
    bit [3:0] ev;
    icw_t     nxt;
    ev = strb & ~prev_strb;
    prev_strb = strb;
    m_valid = 0;
    m_poll  = 0;
    if (ev[0]) begin
      m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
      m_imr = 8'h00; m_aeoi = 0; m_buf = 0; m_ms = 0; m_sfnm = 0;
      m_smm = 0; m_risr = 0; m_cas = 0;
      started = 1;
      pending.delete();
      pending.push_back(W_ICW2);
      if (!d[1]) pending.push_back(W_ICW3);
      if (d[0])  pending.push_back(W_ICW4);
    end else if (ev[1]) begin
      if (started && pending.size() > 0) begin
        nxt = pending.pop_front();
        case (nxt)
          W_ICW2: m_vec = d[7:3];
          W_ICW3: m_cas = d;
          default: begin
            m_sfnm = d[4]; m_buf = d[3]; m_ms = d[2]; m_aeoi = d[1];
          end
        endcase
      end else if (started) begin
        m_imr = d;
      end
    end else if (m_ready()) begin
      if (ev[2]) begin
        m_valid = 1; m_cmd = d[7:5]; m_lvl = d[2:0];
      end
      if (ev[3]) begin
        if (d[1]) m_risr = d[0];
        if (d[2]) m_poll = 1;
`ifdef SPECIAL_MASK_MODE_EN
        if (d[6]) m_smm = d[5];
`endif
      end
    end
  endtask

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check("init_done", 32'(init_done),            32'(m_ready()));
    check("ltim",      32'(level_trigger),        32'(m_ltim));
    check("sngl",      32'(single_mode),          32'(m_sngl));
    check("vector",    32'(vector_base),          32'(m_vec));
    check("cascade",   32'(cascade_cfg),          32'(m_cas));
    check("aeoi",      32'(auto_eoi),             32'(m_aeoi));
    check("buf",       32'(buffered_mode),        32'(m_buf));
    check("ms",        32'(buffer_master),        32'(m_ms));
    check("sfnm",      32'(special_fully_nested), 32'(m_sfnm));
    check("imr",       32'(interrupt_mask),       32'(m_imr));
    check("ocw2_vld",  32'(ocw2_valid),           32'(m_valid));
    check("ocw2_cmd",  32'(ocw2_cmd),             32'(m_cmd));
    check("ocw2_lvl",  32'(ocw2_level),           32'(m_lvl));
    check("risr",      32'(read_isr_sel),         32'(m_risr));
    check("poll",      32'(poll_cmd),             32'(m_poll));
    check("smm",       32'(special_mask_mode),    32'(m_smm));
  endtask

  // ---------------------------------------------------------------- stimulus
  // strb bit order: [0]=ICW1, [1]=A1, [2]=OCW2, [3]=OCW3
  task automatic step(input bit [3:0] strb, input bit [7:0] d);
    @(negedge clk);
    {write_OCW3, write_OCW2, write_ICW2_4, write_ICW_1} = strb;
    internal_bus = d;
    @(posedge clk);
    model_step(strb, d);
    #1 check_all();
  endtask

  task automatic wr(input bit [3:0] strb, input bit [7:0] d);
    step(strb, d);
    step(4'b0000, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    {write_OCW3, write_OCW2, write_ICW2_4, write_ICW_1} = 4'b0000;
    reset_n = 1'b0;
    model_reset();
    #1 check_all();              // asynchronous: no clock edge yet
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
  endtask

  initial begin
    bit [3:0] s;
    bit [7:0] d;
    reset_n = 1'b0;
    internal_bus = 8'h00;
    {write_OCW3, write_OCW2, write_ICW2_4, write_ICW_1} = 4'b0000;
    model_reset();
    do_reset();

    // OCW1 before initialisation is ignored
    wr(4'b0010, 8'hFF);
    check("imr_pre_init", 32'(interrupt_mask), 32'h00);

    // single, ICW4 with AEOI
    wr(4'b0001, 8'h13);
    wr(4'b0010, 8'h40);
    wr(4'b0010, 8'h03);
    check("vec_01000", 32'(vector_base), 32'h08);
    check("aeoi_set",  32'(auto_eoi),    32'h1);
    check("ready_1",   32'(init_done),   32'h1);
    check("cas_kept",  32'(cascade_cfg), 32'h00);

    // cascaded, ICW3 + ICW4, then OCW1
    wr(4'b0001, 8'h11);
    wr(4'b0010, 8'h20);
    wr(4'b0010, 8'h04);
    check("not_ready_icw4", 32'(init_done), 32'h0);
    wr(4'b0010, 8'h01);
    check("cas_04",   32'(cascade_cfg), 32'h04);
    check("ready_2",  32'(init_done),   32'h1);
    wr(4'b0010, 8'hA5);
    check("imr_a5",   32'(interrupt_mask), 32'hA5);

    // OCW2 pulse, OCW3 read select and poll
    step(4'b0100, 8'h63);
    check("ocw2_pulse", 32'(ocw2_valid), 32'h1);
    check("ocw2_cmd_3", 32'(ocw2_cmd),   32'h3);
    step(4'b0000, 8'h63);
    check("ocw2_drop",  32'(ocw2_valid), 32'h0);
    wr(4'b1000, 8'h0B);
    check("risr_1",     32'(read_isr_sel), 32'h1);
    step(4'b1000, 8'h0C);
    check("poll_pulse", 32'(poll_cmd), 32'h1);
    step(4'b0000, 8'h0C);
    wr(4'b1000, 8'h68);
    wr(4'b1000, 8'h48);

    // held A1 strobe with changing data: only the first word counts
    for (int i = 0; i < 5; i++) step(4'b0010, 8'h5A + 8'(i));
    step(4'b0000, 8'h00);
    check("imr_held", 32'(interrupt_mask), 32'h5A);

    // ICW1 in WAIT_ICW3 restarts the sequence
    wr(4'b0001, 8'h11);
    wr(4'b0010, 8'h20);
    wr(4'b0001, 8'h10);
    check("imr_restart", 32'(interrupt_mask), 32'h00);
    wr(4'b0010, 8'h30);
    check("vec_restart", 32'(vector_base), 32'h06);

    // reset mid-sequence
    do_reset();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      d = 8'($urandom);
      case ($urandom_range(0, 19))
        0:             s = 4'b0001;
        1:             s = 4'($urandom);
        2, 3, 4, 5:    s = 4'b0010;
        6, 7:          s = 4'b0100;
        8, 9:          s = 4'b1000;
        default:       s = 4'b0000;
      endcase
      if (s[2] && s[3]) s[3] = 1'b0;
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(s, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
